// File: rtl/bin2bcd_seq_ctrl.sv
// Sequencer for a serial shift-add-3 BCD digit chain; DONE_VALID rises WIDTH+1 edges after accept, result holds while DONE_READY=0.
// Optional overflow tracking is enabled by defining BIN2BCD_SEQ_CTRL_OVF_EN; otherwise OVF is tied low.
module bin2bcd_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int NDIG  = 3
) (
  input  logic              CLK,
  input  logic              RST_BAR,
  input  logic              START_VALID,
  output logic              START_READY,
  input  logic [WIDTH-1:0]  BIN_IN,
  output logic              DIG_INIT_BAR,
  output logic              SER_BIT,
  input  logic [4*NDIG-1:0] BCD_IN,
  input  logic              OVF_IN,
  output logic              DONE_VALID,
  input  logic              DONE_READY,
  output logic [4*NDIG-1:0] BCD_OUT,
  output logic              OVF
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CAPT, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q;
  logic [CW-1:0]      cnt_q;
  logic [4*NDIG-1:0]  bcd_q;

  always_ff @(posedge CLK or negedge RST_BAR) begin
    if (!RST_BAR) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START_VALID) state_d = SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = CAPT;
      CAPT:    state_d = DONE;
      DONE:    if (DONE_READY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The digit cells have no enable: INIT_BAR may only be high while shifting.
  always_comb begin
    START_READY  = 1'b0;
    DIG_INIT_BAR = 1'b0;
    SER_BIT      = 1'b0;
    DONE_VALID   = 1'b0;
    case (state_q)
      IDLE:  START_READY = 1'b1;
      SHIFT: begin
        DIG_INIT_BAR = 1'b1;
        SER_BIT      = shreg_q[WIDTH-1];
      end
      DONE:  DONE_VALID = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_BAR) begin
    if (!RST_BAR) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (START_VALID) begin
          shreg_q <= BIN_IN;
          cnt_q   <= CNT_INIT;
        end
        SHIFT: begin
          shreg_q <= shreg_q << 1;
          cnt_q   <= cnt_q - CW'(1);
        end
        CAPT: bcd_q <= BCD_IN;
        default: ;
      endcase
    end
  end

  assign BCD_OUT = bcd_q;

`ifdef BIN2BCD_SEQ_CTRL_OVF_EN
  logic ovf_sticky_q, ovf_q;

  // Sampled on every shift edge including the last, so a carry produced by the final shift is caught.
  always_ff @(posedge CLK or negedge RST_BAR) begin
    if (!RST_BAR) begin
      ovf_sticky_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    if (START_VALID) ovf_sticky_q <= 1'b0;
        SHIFT:   ovf_sticky_q <= ovf_sticky_q | OVF_IN;
        CAPT:    ovf_q <= ovf_sticky_q;
        default: ;
      endcase
    end
  end

  assign OVF = ovf_q;
`else
  logic ovf_in_unused;
  assign ovf_in_unused = OVF_IN;
  assign OVF = 1'b0;
`endif

endmodule
